// File: rtl/pll_sup_pkg.sv
// Shared types and default cycle constants for the PLL lock supervisor.
package pll_sup_pkg;

  typedef enum logic [2:0] {
    RESET_PLL,
    WAIT_LOCK,
    STABILIZE,
    RUN,
    FAULT
  } sup_state_e;

  localparam int unsigned DefRstPulseCycles   = 16;
  localparam int unsigned DefLockStableCycles = 1024;
  localparam int unsigned DefLockTimeoutCycles = 1000000;
  localparam int unsigned DefMaxRetries       = 3;
  localparam int unsigned DefCntW             = 20;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer, asynchronous active-low reset to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  // Two back-to-back flops; the first may go metastable, the second settles it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/pll_lock_supervisor.sv
// Sequences PLL reset, waits for lock with timeout/retries, debounces lock and
// gates the core reset. All outputs are registered and decoded from next state.
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int unsigned RST_PULSE_CYCLES    = DefRstPulseCycles,
  parameter int unsigned LOCK_STABLE_CYCLES  = DefLockStableCycles,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = DefLockTimeoutCycles,
  parameter int unsigned MAX_RETRIES         = DefMaxRetries,
  parameter int unsigned CNT_W               = DefCntW
) (
  input  logic       refclk,
  input  logic       reset_n,
  input  logic       pll_locked,
  input  logic       restart,
  output logic       pll_rst,
  output logic       core_reset_n,
  output logic       lock_lost,
  output logic       fault,
  output logic [1:0] retry_count
);

  localparam logic [CNT_W-1:0] RstLast     = CNT_W'(RST_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] StableLast  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [1:0]       RetryMax    = 2'(MAX_RETRIES);

  sup_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [1:0]       retry_q, retry_d;
  logic             locked_s;

  logic pll_rst_q, pll_rst_d;
  logic core_rst_n_q, core_rst_n_d;
  logic lock_lost_q, lock_lost_d;
  logic fault_q, fault_d;

  sync_2ff u_lock_sync (
    .clk   (refclk),
    .rst_n (reset_n),
    .d     (pll_locked),
    .q     (locked_s)
  );

  // Saturating increment so a stalled count never wraps back to a match.
  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

  // State, counter, retry and output registers.
  always_ff @(posedge refclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= RESET_PLL;
      cnt_q        <= '0;
      retry_q      <= 2'd0;
      pll_rst_q    <= 1'b1;
      core_rst_n_q <= 1'b0;
      lock_lost_q  <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      retry_q      <= retry_d;
      pll_rst_q    <= pll_rst_d;
      core_rst_n_q <= core_rst_n_d;
      lock_lost_q  <= lock_lost_d;
      fault_q      <= fault_d;
    end
  end

  // Next-state, counter and retry logic; restart overrides everything.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_inc;
    retry_d = retry_q;
    case (state_q)
      RESET_PLL: begin
        if (cnt_q == RstLast) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end
      end
      WAIT_LOCK: begin
        // Lock is checked first so it wins against a same-cycle timeout.
        if (locked_s) begin
          state_d = STABILIZE;
          cnt_d   = '0;
        end else if (cnt_q == TimeoutLast) begin
          cnt_d = '0;
          if (retry_q == RetryMax) begin
            state_d = FAULT;
          end else begin
            state_d = RESET_PLL;
            retry_d = retry_q + 2'd1;
          end
        end
      end
      STABILIZE: begin
        if (!locked_s) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == StableLast) begin
          state_d = RUN;
          cnt_d   = '0;
          retry_d = 2'd0;
        end
      end
      RUN: begin
        cnt_d = '0;
        if (!locked_s) begin
          state_d = RESET_PLL;
          retry_d = 2'd0;
        end
      end
      FAULT: begin
        cnt_d = '0;
      end
      default: begin
        state_d = RESET_PLL;
        cnt_d   = '0;
      end
    endcase
    if (restart) begin
      state_d = RESET_PLL;
      cnt_d   = '0;
      retry_d = 2'd0;
    end
  end

  // Output decode from the next state so outputs change on the transition edge.
  always_comb begin
    pll_rst_d    = (state_d == RESET_PLL);
    core_rst_n_d = (state_d == RUN);
    fault_d      = (state_d == FAULT);
    lock_lost_d  = (state_q == RUN) && !locked_s && !restart;
  end

  assign pll_rst      = pll_rst_q;
  assign core_reset_n = core_rst_n_q;
  assign lock_lost    = lock_lost_q;
  assign fault        = fault_q;
  assign retry_count  = retry_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Self-checking bench for pll_lock_supervisor: directed scenarios followed by
// randomized attempt plans. Expected timings come from the sequencing rules:
// pulse = P cycles, timeout = T low cycles, lock release S+3 edges after the
// lock pin rises, lock-loss reaction 3 edges after the pin falls.
module tb_pll_lock_supervisor;

  localparam int unsigned P = 4;
  localparam int unsigned S = 8;
  localparam int unsigned T = 32;
  localparam int unsigned M = 2;
  localparam int unsigned LockLat = S + 3;
  localparam int unsigned LossLat = 3;
  localparam int unsigned Bound = 200;

  logic       refclk = 1'b0;
  logic       reset_n = 1'b0;
  logic       pll_locked = 1'b0;
  logic       restart = 1'b0;
  logic       pll_rst;
  logic       core_reset_n;
  logic       lock_lost;
  logic       fault;
  logic [1:0] retry_count;

  int tests = 0;
  int fails = 0;

  pll_lock_supervisor #(
    .RST_PULSE_CYCLES    (P),
    .LOCK_STABLE_CYCLES  (S),
    .LOCK_TIMEOUT_CYCLES (T),
    .MAX_RETRIES         (M),
    .CNT_W               (20)
  ) dut (
    .refclk       (refclk),
    .reset_n      (reset_n),
    .pll_locked   (pll_locked),
    .restart      (restart),
    .pll_rst      (pll_rst),
    .core_reset_n (core_reset_n),
    .lock_lost    (lock_lost),
    .fault        (fault),
    .retry_count  (retry_count)
  );

  always #5 refclk = ~refclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge refclk);
    #1;
  endtask

  // Samples (including the current one) while pll_rst is high.
  task automatic measure_high(output int n);
    n = 0;
    while (pll_rst === 1'b1 && n < Bound) begin
      n++;
      cyc();
    end
  endtask

  task automatic wait_core_high(output int n);
    n = 0;
    while (core_reset_n !== 1'b1 && n < Bound) begin
      cyc();
      n++;
    end
  endtask

  task automatic do_restart();
    int n;
    pll_locked = 1'b0;
    restart = 1'b1;
    cyc();
    restart = 1'b0;
    check("restart_fault", fault, 0);
    check("restart_retry", retry_count, 0);
    check("restart_core", core_reset_n, 0);
    measure_high(n);
    check("restart_pulse", n, P);
  endtask

  // Attempt a that is expected to lock: pin rises d cycles after pll_rst falls.
  task automatic lock_attempt(input int a, input int d, input bit glitch, input int gpos);
    int n;
    repeat (d) cyc();
    check("wait_retry", retry_count, a);
    check("wait_pll_rst", pll_rst, 0);
    pll_locked = 1'b1;
    if (glitch) begin
      repeat (gpos) cyc();
      check("glitch_core_held", core_reset_n, 0);
      pll_locked = 1'b0;
      cyc();
      pll_locked = 1'b1;
      cyc();
      cyc();
      check("glitch_retry_kept", retry_count, a);
      wait_core_high(n);
      check("glitch_release_lat", n + 2, LockLat);
    end else begin
      wait_core_high(n);
      check("lock_release_lat", n, LockLat);
    end
    check("run_retry", retry_count, 0);
    check("run_pll_rst", pll_rst, 0);
    check("run_fault", fault, 0);
  endtask

  // Attempt a that never sees lock; the last permitted one ends in fault.
  task automatic fail_attempt(input int a);
    int n;
    n = 0;
    while (pll_rst !== 1'b1 && fault !== 1'b1 && n < Bound) begin
      cyc();
      n++;
    end
    check("timeout_len", n, T);
    if (a == int'(M)) begin
      check("fault_set", fault, 1);
      check("fault_pll_rst", pll_rst, 0);
      check("fault_core", core_reset_n, 0);
      check("fault_retry", retry_count, M);
    end else begin
      check("retry_pll_rst", pll_rst, 1);
      check("retry_inc", retry_count, a + 1);
      check("retry_fault", fault, 0);
      measure_high(n);
      check("retry_pulse", n, P);
    end
  endtask

  task automatic lose_lock();
    int n;
    pll_locked = 1'b0;
    n = 0;
    while (core_reset_n === 1'b1 && n < Bound) begin
      cyc();
      n++;
    end
    check("loss_latency", n, LossLat);
    check("loss_pulse", lock_lost, 1);
    check("loss_pll_rst", pll_rst, 1);
    check("loss_retry", retry_count, 0);
    cyc();
    check("loss_pulse_end", lock_lost, 0);
    measure_high(n);
    check("loss_rst_pulse", n + 1, P);
  endtask

  initial begin
    int n;
    int nfail;

    // Reset state while reset_n is held low with the clock running.
    repeat (3) cyc();
    check("rst_pll_rst", pll_rst, 1);
    check("rst_core", core_reset_n, 0);
    check("rst_lock_lost", lock_lost, 0);
    check("rst_fault", fault, 0);
    check("rst_retry", retry_count, 0);

    // Normal lock, pin rising 10 cycles after pll_rst falls.
    reset_n = 1'b1;
    measure_high(n);
    check("first_pulse", n, P);
    lock_attempt(0, 10, 1'b0, 0);

    // Lock loss in RUN, then relock at the lock/timeout coincidence boundary.
    lose_lock();
    lock_attempt(0, T - 3, 1'b0, 0);

    // Never lock: three attempts, then fault which stays sticky.
    do_restart();
    for (int a = 0; a <= int'(M); a++) fail_attempt(a);
    repeat (5) cyc();
    check("fault_sticky", fault, 1);
    check("fault_sticky_core", core_reset_n, 0);

    // Recovery from fault, with a one-cycle glitch after 5 stabilize cycles.
    do_restart();
    lock_attempt(0, 3, 1'b1, 8);

    // Mid-STABILIZE asynchronous reset takes effect without a clock edge.
    lose_lock();
    pll_locked = 1'b1;
    repeat (7) cyc();
    #2;
    reset_n = 1'b0;
    #1;
    check("async_pll_rst", pll_rst, 1);
    check("async_core", core_reset_n, 0);
    check("async_retry", retry_count, 0);
    pll_locked = 1'b0;
    cyc();
    reset_n = 1'b1;
    measure_high(n);
    check("post_reset_pulse", n, P);
    lock_attempt(0, 5, 1'b0, 0);

    // Randomized plans: nfail failed attempts precede a lock; M+1 means fault.
    for (int trial = 0; trial < 8; trial++) begin
      do_restart();
      nfail = $urandom_range(0, M + 1);
      for (int a = 0; a < nfail; a++) fail_attempt(a);
      if (nfail <= int'(M)) begin
        lock_attempt(nfail, $urandom_range(0, T - 3), 1'($urandom_range(0, 1)),
                     $urandom_range(1, S + 1));
        if ($urandom_range(0, 1) == 1) begin
          lose_lock();
          lock_attempt(0, $urandom_range(0, T - 3), 1'b0, 0);
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
